// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, borrowing the shared ALU adder
// Optional feature macro: MULDIV_EARLY_OUT_EN (half-length multiply when |rt| fits in WIDTH/2 bits)
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  input  logic             i_flush,
  input  logic             i_hilo_we,
  input  logic             i_hilo_sel,
  input  logic [WIDTH-1:0] i_hilo_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_alu_req,
  input  logic             i_alu_gnt,
  output logic [WIDTH-1:0] o_alu_data1,
  output logic [WIDTH-1:0] o_alu_data2,
  output logic             o_alu_arith_op,
  output logic [1:0]       o_alu_select,
  output logic             o_alu_sign,
  input  logic [WIDTH-1:0] i_alu_data,
  input  logic             i_alu_less
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`ifdef MULDIV_EARLY_OUT_EN
  localparam int HW = WIDTH / 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(HW);
`endif

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ITER, S_FIX, S_DONE} state_t;

  state_t state_q, state_d;

  // raw operands are kept so a divide by zero can return the untouched dividend in HI
  logic [WIDTH-1:0] rs_q, rs_d, rt_q, rt_d;
  logic             is_div_q, is_div_d, is_sgn_q, is_sgn_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  // acc doubles as the remainder, pl as the quotient, m as the divisor
  logic [WIDTH-1:0] acc_q, acc_d, pl_q, pl_d, m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
`ifdef MULDIV_EARLY_OUT_EN
  logic             early_q, early_d;
`endif

  logic               start_ok, div_by_zero;
  logic [WIDTH-1:0]   rs_abs, rt_abs, sh_rem, sum;
  logic               shift_out, carry, ge;
  logic [2*WIDTH-1:0] prod;

  assign start_ok    = (state_q == S_IDLE) && i_start && !i_flush;
  assign div_by_zero = is_div_q && (rt_q == '0);
  assign rs_abs      = (is_sgn_q && rs_q[WIDTH-1]) ? (~rs_q + 1'b1) : rs_q;
  assign rt_abs      = (is_sgn_q && rt_q[WIDTH-1]) ? (~rt_q + 1'b1) : rt_q;
  assign sh_rem      = {acc_q[WIDTH-2:0], pl_q[WIDTH-1]};
  assign shift_out   = acc_q[WIDTH-1];
  assign ge          = shift_out | ~i_alu_less;
  assign sum         = pl_q[0] ? i_alu_data : acc_q;
  // carry out of the borrowed adder rebuilt from operand and sum MSBs
  assign carry       = pl_q[0] & ((acc_q[WIDTH-1] & m_q[WIDTH-1]) |
                                  ((acc_q[WIDTH-1] | m_q[WIDTH-1]) & ~i_alu_data[WIDTH-1]));

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic; flush beats every other transition
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (i_start) state_d = S_SETUP;
        S_SETUP: state_d = div_by_zero ? S_FIX : S_ITER;
        S_ITER:  if (i_alu_gnt && (cnt_q == CNT_ONE)) state_d = S_FIX;
        S_FIX:   state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // datapath next values: latch, setup, one shift/add step per grant, final sign fix
  always_comb begin
    rs_d      = rs_q;
    rt_d      = rt_q;
    is_div_d  = is_div_q;
    is_sgn_d  = is_sgn_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    pl_d      = pl_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MULDIV_EARLY_OUT_EN
    early_d   = early_q;
`endif
    prod      = {acc_q, pl_q};
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          rs_d      = i_rs;
          rt_d      = i_rt;
          is_div_d  = i_op[1];
          is_sgn_d  = ~i_op[0];
          neg_quo_d = ~i_op[0] & (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
          neg_rem_d = ~i_op[0] & i_rs[WIDTH-1];
        end else if (i_hilo_we) begin
          if (i_hilo_sel) hi_d = i_hilo_wdata;
          else            lo_d = i_hilo_wdata;
        end
      end
      S_SETUP: begin
        acc_d = '0;
        cnt_d = CNT_FULL;
        if (div_by_zero) begin
          acc_d     = rs_q;
          pl_d      = '1;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
        end else if (is_div_q) begin
          pl_d = rs_abs;
          m_d  = rt_abs;
        end else begin
          pl_d = rt_abs;
          m_d  = rs_abs;
`ifdef MULDIV_EARLY_OUT_EN
          early_d = (rt_abs[WIDTH-1:HW] == '0);
          if (early_d) cnt_d = CNT_HALF;
`endif
        end
      end
      S_ITER: begin
        if (i_alu_gnt) begin
          cnt_d = cnt_q - CNT_ONE;
          if (is_div_q) begin
            acc_d = ge ? i_alu_data : sh_rem;
            pl_d  = {pl_q[WIDTH-2:0], ge};
          end else begin
            acc_d = {carry, sum[WIDTH-1:1]};
            pl_d  = {sum[0], pl_q[WIDTH-1:1]};
          end
        end
      end
      S_FIX: begin
        if (!i_flush) begin
          if (is_div_q) begin
            lo_d = neg_quo_q ? (~pl_q + 1'b1) : pl_q;
            hi_d = neg_rem_q ? (~acc_q + 1'b1) : acc_q;
          end else begin
`ifdef MULDIV_EARLY_OUT_EN
            if (early_q) prod = prod >> HW;
`endif
            if (neg_quo_q) prod = ~prod + 1'b1;
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rs_q      <= '0;
      rt_q      <= '0;
      is_div_q  <= 1'b0;
      is_sgn_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      pl_q      <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      early_q   <= 1'b0;
`endif
    end else begin
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      is_div_q  <= is_div_d;
      is_sgn_q  <= is_sgn_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      pl_q      <= pl_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MULDIV_EARLY_OUT_EN
      early_q   <= early_d;
`endif
    end
  end

  // outputs decoded from state; ALU operands are quiet outside ITER
  always_comb begin
    o_busy         = (state_q != S_IDLE);
    o_done         = (state_q == S_DONE);
    o_alu_req      = (state_q == S_ITER);
    o_alu_data1    = '0;
    o_alu_data2    = '0;
    o_alu_arith_op = 1'b0;
    if (state_q == S_ITER) begin
      o_alu_data2 = m_q;
      if (is_div_q) begin
        o_alu_data1    = sh_rem;
        o_alu_arith_op = 1'b1;
      end else begin
        o_alu_data1 = acc_q;
      end
    end
  end

  assign o_hi         = hi_q;
  assign o_lo         = lo_q;
  assign o_alu_select = 2'd2;
  assign o_alu_sign   = 1'b0;

endmodule
